// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared state encoding, default widths and sizing helper for the resampler
package audio_pkg;

    localparam int DEF_DATA_W  = 24;
    localparam int DEF_FRAC_W  = 11;
    localparam int DEF_CH      = 2;
    localparam int DEF_OUT_DIV = 512;
    localparam int TEST_A_W    = 11;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_MUL0 = 3'd1,
        ST_MUL1 = 3'd2,
        ST_OUT  = 3'd3
    } rs_state_e;

    // Counter width for a modulus of v, never narrower than one bit.
    function automatic int cnt_width(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/resampler_mac.sv
// rtl/resampler_mac.sv - shared signed multiplier with one accumulator for the two interpolation terms
module resampler_mac #(
    parameter int DATA_W = 24,
    parameter int FRAC_W = 11,
    parameter int OUT_W  = DATA_W + FRAC_W + 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     load_i,
    input  logic signed [DATA_W-1:0] sample_i,
    input  logic        [FRAC_W:0]   coef_i,
    output logic signed [OUT_W-1:0]  sum_o
);

    localparam int PW = DATA_W + FRAC_W + 2;

    logic signed [PW-1:0]    sample_ext;
    logic signed [PW-1:0]    coef_ext;
    logic signed [PW-1:0]    prod_full;
    logic signed [OUT_W-1:0] prod;
    logic signed [OUT_W-1:0] acc_q;
    logic signed [OUT_W-1:0] acc_d;

    // Coefficients are unsigned weights; a zero MSB keeps them positive in the signed product.
    assign sample_ext = PW'(sample_i);
    assign coef_ext   = PW'($signed({1'b0, coef_i}));
    assign prod_full  = sample_ext * coef_ext;

    // Weights sum to at most 2^FRAC_W, so the product and the sum both fit in OUT_W.
    assign prod  = $signed(prod_full[OUT_W-1:0]);
    assign acc_d = load_i ? prod : acc_q;
    assign sum_o = acc_q + prod;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/linear_resampler.sv
// rtl/linear_resampler.sv - linear-interpolating sample-rate converter; LINEAR_RESAMPLER_TEST_EN adds test_data
module linear_resampler
    import audio_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int FRAC_W  = DEF_FRAC_W,
    parameter int CH      = DEF_CH,
    parameter int OUT_DIV = DEF_OUT_DIV,
    localparam int OUT_W  = DATA_W + FRAC_W + 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   run,
    input  logic                   din_en,
    input  logic [CH*DATA_W-1:0]   din,
    input  logic                   dout_ready,
    output logic                   dout_valid,
    output logic [CH*OUT_W-1:0]    dout,
    output logic                   overrun
`ifdef LINEAR_RESAMPLER_TEST_EN
    ,
    output logic [15:0]            test_data
`endif
);

    localparam int CH_W  = cnt_width(CH);
    localparam int DIV_W = cnt_width(OUT_DIV);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CH - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(OUT_DIV - 1);

    logic        [FRAC_W-1:0] cnt_q;
    logic        [FRAC_W:0]   period_q;
    logic signed [DATA_W-1:0] s0_q [CH];
    logic signed [DATA_W-1:0] s1_q [CH];
    logic        [1:0]        strb_q;
    logic                     primed;

    logic [DIV_W-1:0] div_q;
    logic             tick_q;

    rs_state_e                state_q, state_d;
    logic        [CH_W-1:0]   ch_q, ch_d;
    logic                     dout_valid_q, dout_valid_d;
    logic                     overrun_q, overrun_d;
    logic                     capture;
    logic                     mac_load;
    logic                     dout_we;

    logic        [FRAC_W-1:0] a_now;
    logic        [FRAC_W-1:0] a_q;
    logic        [FRAC_W:0]   p_q;
    logic signed [DATA_W-1:0] cap0_q [CH];
    logic signed [DATA_W-1:0] cap1_q [CH];
    logic signed [OUT_W-1:0]  dout_q [CH];

    logic signed [DATA_W-1:0] mac_sample;
    logic        [FRAC_W:0]   mac_coef;
    logic signed [OUT_W-1:0]  mac_sum;

    // ---------------- input side: sub-sample position and sample history ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q    <= '0;
            period_q <= '0;
            for (int k = 0; k < CH; k++) begin
                s0_q[k] <= '0;
                s1_q[k] <= '0;
            end
        end else if (din_en) begin
            period_q <= {1'b0, cnt_q} + (FRAC_W+1)'(1);
            cnt_q    <= '0;
            for (int k = 0; k < CH; k++) begin
                s1_q[k] <= s0_q[k];
                s0_q[k] <= $signed(din[k*DATA_W +: DATA_W]);
            end
        end else if (cnt_q != '1) begin
            cnt_q <= cnt_q + FRAC_W'(1);
        end
    end

    // Two strobes are needed before both history slots hold real samples.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            strb_q <= '0;
        end else if (!run) begin
            strb_q <= '0;
        end else if (din_en && !strb_q[1]) begin
            strb_q <= strb_q + 2'd1;
        end
    end

    assign primed = strb_q[1];

    // A stalled input lets cnt run past the last period; clamp to it.
    assign a_now = ({1'b0, cnt_q} > period_q) ? period_q[FRAC_W-1:0] : cnt_q;

    // ---------------- output tick divider ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else if (!run) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            tick_q <= (div_q == DIV_LAST);
            div_q  <= (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        end
    end

    // ---------------- frame sequencer ----------------
    always_comb begin
        state_d      = state_q;
        ch_d         = ch_q;
        dout_valid_d = dout_valid_q;
        overrun_d    = overrun_q;
        capture      = 1'b0;
        mac_load     = 1'b0;
        dout_we      = 1'b0;
        if (!run) begin
            state_d      = ST_IDLE;
            ch_d         = '0;
            dout_valid_d = 1'b0;
            overrun_d    = 1'b0;
        end else begin
            if (tick_q && state_q != ST_IDLE) begin
                overrun_d = 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (tick_q && primed) begin
                        capture = 1'b1;
                        ch_d    = '0;
                        state_d = ST_MUL0;
                    end
                end
                ST_MUL0: begin
                    mac_load = 1'b1;
                    state_d  = ST_MUL1;
                end
                ST_MUL1: begin
                    dout_we = 1'b1;
                    if (ch_q == CH_LAST) begin
                        state_d = ST_OUT;
                    end else begin
                        ch_d    = ch_q + CH_W'(1);
                        state_d = ST_MUL0;
                    end
                end
                ST_OUT: begin
                    // First OUT cycle raises valid; the frame leaves only once it was seen valid.
                    if (dout_valid_q && dout_ready) begin
                        dout_valid_d = 1'b0;
                        state_d      = ST_IDLE;
                    end else begin
                        dout_valid_d = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            ch_q         <= '0;
            dout_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ch_q         <= ch_d;
            dout_valid_q <= dout_valid_d;
            overrun_q    <= overrun_d;
        end
    end

    // Snapshot taken from pre-strobe registers, so a coincident din_en does not disturb it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_q <= '0;
            p_q <= '0;
            for (int k = 0; k < CH; k++) begin
                cap0_q[k] <= '0;
                cap1_q[k] <= '0;
            end
        end else if (capture) begin
            a_q <= a_now;
            p_q <= period_q;
            for (int k = 0; k < CH; k++) begin
                cap0_q[k] <= s0_q[k];
                cap1_q[k] <= s1_q[k];
            end
        end
    end

    // ---------------- shared datapath ----------------
    assign mac_sample = (state_q == ST_MUL0) ? cap0_q[ch_q] : cap1_q[ch_q];
    assign mac_coef   = (state_q == ST_MUL0) ? {1'b0, a_q} : (p_q - {1'b0, a_q});

    resampler_mac #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .OUT_W  (OUT_W)
    ) u_mac (
        .clk      (clk),
        .reset_n  (reset_n),
        .load_i   (mac_load),
        .sample_i (mac_sample),
        .coef_i   (mac_coef),
        .sum_o    (mac_sum)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < CH; k++) begin
                dout_q[k] <= '0;
            end
        end else if (dout_we) begin
            dout_q[ch_q] <= mac_sum;
        end
    end

    for (genvar k = 0; k < CH; k++) begin : g_dout
        assign dout[k*OUT_W +: OUT_W] = dout_q[k];
    end

    assign dout_valid = dout_valid_q;
    assign overrun    = overrun_q;

`ifdef LINEAR_RESAMPLER_TEST_EN
    assign test_data = {state_q, din_en, tick_q, TEST_A_W'(a_now)};
`endif

endmodule

// File: doc/linear_resampler.md
LINEAR_RESAMPLER -- requirements
Module: linear_resampler

Interface
REQ-001 SHALL have parameter DATA_W, default 24, meaning signed input sample width per channel.
REQ-002 SHALL have parameter FRAC_W, default 11, meaning sub-sample counter and coefficient width.
REQ-003 SHALL have parameter CH, default 2, meaning channel count (1..8).
REQ-004 SHALL have parameter OUT_DIV, default 512, meaning clocks per output tick (49.152 MHz / 512 = 96 kHz).
REQ-005 SHALL have localparam OUT_W = DATA_W+FRAC_W+1, meaning signed output width per channel.
REQ-006 SHALL have port clk  input  1  system clock; the block uses only this one clock.
REQ-007 SHALL have port reset_n  input  1  reset, asynchronous and active-low.
REQ-008 SHALL have port run  input  1  enable; low clears tick divider, state machine and overrun.
REQ-009 SHALL have port din_en  input  1  one-cycle strobe; all channels are valid on din.
REQ-010 SHALL have port din  input  CH*DATA_W  channel k at bits [k*DATA_W +: DATA_W].
REQ-011 SHALL have port dout_ready  input  1  consumer accepts dout.
REQ-012 SHALL have port dout_valid  output  1  dout holds a complete frame.
REQ-013 SHALL have port dout  output  CH*OUT_W  channel k at bits [k*OUT_W +: OUT_W].
REQ-014 SHALL have port overrun  output  1  sticky flag: a tick was dropped.

Function
REQ-015 SHALL keep sub-sample counter cnt: on din_en, period <= cnt+1 and cnt <= 0; otherwise cnt increments, saturating at 2^FRAC_W-1.
REQ-016 SHALL on din_en shift each channel: s1[k] <= s0[k], s0[k] <= din slice; it SHALL set primed after the second strobe since reset or since run fell.
REQ-017 SHALL pulse tick for one cycle every OUT_DIV clocks while run=1; the first tick comes OUT_DIV clocks after run rises.
REQ-018 SHALL, on tick with state IDLE and primed=1, capture a = min(cnt, period), p = period, and all s0/s1; on din_en in the same cycle, pre-strobe values are captured.
REQ-019 SHALL discard a tick while primed=0 and leave overrun unchanged.
REQ-020 SHALL use states IDLE -> MUL0 -> MUL1 (repeated per channel, one shared signed multiplier) -> OUT -> IDLE.
REQ-021 SHALL in MUL0 set acc = s0[k]*a; in MUL1 write dout[k] = acc + s1[k]*(p-a), sign-extended to OUT_W, with no overflow possible.
REQ-022 SHALL assert dout_valid exactly 2*CH+2 cycles after the tick cycle, 6 cycles at defaults.
REQ-023 SHALL hold dout_valid and dout stable in OUT until dout_ready=1, then return to IDLE in the next cycle; dout keeps its last value afterwards.
REQ-024 SHALL, on a tick outside IDLE, drop the tick, set overrun, and leave the frame in progress unaffected.
REQ-025 SHALL, when run=0, force IDLE, clear dout_valid, overrun, primed and the divider; cnt, period and samples keep tracking din_en.

Reset
REQ-026 SHALL, while reset_n=0, clear dout_valid=0, dout=0, overrun=0, state=IDLE, cnt=0, period=0, primed=0, all samples=0.
REQ-027 SHALL treat reset assertion mid-frame as immediate abort with no partial dout_valid; after release, behaviour is identical to power-up.

Configuration
REQ-028 SHALL, with LINEAR_RESAMPLER_TEST_EN defined, add output test_data[15:0] = {state[2:0], din_en, tick, a[10:0]}, with a as defined in REQ-018.
REQ-029 SHALL, without LINEAR_RESAMPLER_TEST_EN, omit the test_data port and its logic, with identical functional behaviour.

Structure
REQ-030 SHALL place state encoding (3-bit enum) and default width constants in shared package audio_pkg.
REQ-031 SHALL isolate the shared multiply-accumulate datapath in one sub-module, resampler_mac.

Verification
REQ-032 SHALL cover: OUT_DIV=16, strobes every 8 clk, s1=1000, s0=2000, tick at a=2 -> p=8, dout=1000*6+2000*2=10000.
REQ-033 SHALL cover: s1=-100, s0=100, a=4, p=8 -> dout=0; and a=0 -> dout=-800.
REQ-034 SHALL cover: input stalled 40 clk after last strobe, p=8 -> a clamped to 8, dout=s0*8.
REQ-035 SHALL cover: dout_ready held 0 for 20 clk with OUT_DIV=16 -> dout stable, one tick dropped, overrun=1 until run falls.
REQ-036 SHALL cover: din_en coincident with tick -> capture uses pre-strobe s0/s1/cnt; CH=4 -> dout_valid 10 cycles after tick.
REQ-037 SHALL cover: reset_n pulsed low during MUL1 -> dout_valid never asserts, all outputs 0, first frame only after two new strobes.
